// File: rtl/usb_burst_rw_seq_if.sv
// Request/response bundle between the host task layer, the burst
// sequencer and the USB protocol handler.
interface usb_burst_rw_seq_if #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 16,
    parameter int MAX_PAGES = 4
) ();
    localparam int CNT_W = $clog2(MAX_PAGES + 1);

    // host request side
    logic              start;
    logic              is_read;
    logic [ADDR_W-1:0] mem_page;
    logic [CNT_W-1:0]  num_pages;
    logic              abort;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              success;
    logic [CNT_W-1:0]  pages_done;

    // protocol handler side
    logic              txn_req;
    logic              txn_in;
    logic [6:0]        txn_addr;
    logic [3:0]        txn_endp;
    logic [DATA_W-1:0] txn_out_data;
    logic              txn_ack;
    logic              txn_ok;
    logic [DATA_W-1:0] txn_in_data;

    // environment: host task layer plus protocol handler
    modport master (
        output start, is_read, mem_page, num_pages, abort, wr_data, wr_valid,
               txn_ack, txn_ok, txn_in_data,
        input  wr_ready, rd_data, rd_valid, busy, done, success, pages_done,
               txn_req, txn_in, txn_addr, txn_endp, txn_out_data
    );

    // the burst sequencer
    modport slave (
        input  start, is_read, mem_page, num_pages, abort, wr_data, wr_valid,
               txn_ack, txn_ok, txn_in_data,
        output wr_ready, rd_data, rd_valid, busy, done, success, pages_done,
               txn_req, txn_in, txn_addr, txn_endp, txn_out_data
    );
endinterface

// File: rtl/usb_burst_rw_seq.sv
// Burst read/write sequencer: one host request becomes a run of page
// transfers, each an address OUT followed by a data OUT or IN, with a
// bounded retry per protocol transaction and abort support.
module usb_burst_rw_seq #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 16,
    parameter int MAX_PAGES = 4,
    parameter int MAX_RETRY = 8,
    parameter int DEV_ADDR  = 5,
    parameter int ADDR_ENDP = 4,
    parameter int DATA_ENDP = 8
) (
    input logic             clk,
    input logic             rst_L,
    usb_burst_rw_seq_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_PAGES + 1);
    localparam int RET_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] MAX_PG   = CNT_W'(MAX_PAGES);
    // failures seen before the one that exhausts the budget
    localparam logic [RET_W-1:0] RET_LAST = RET_W'(MAX_RETRY - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR_REQ  = 3'd1;
    localparam logic [2:0] S_ADDR_WAIT = 3'd2;
    localparam logic [2:0] S_WR_FETCH  = 3'd3;
    localparam logic [2:0] S_DATA_REQ  = 3'd4;
    localparam logic [2:0] S_DATA_WAIT = 3'd5;
    localparam logic [2:0] S_NEXT      = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]        state_q, state_d;
    logic              is_read_q, is_read_d;
    logic [ADDR_W-1:0] page_q, page_d;
    logic [CNT_W-1:0]  npages_q, npages_d;
    logic [CNT_W-1:0]  pages_done_q, pages_done_d;
    logic [RET_W-1:0]  retry_q, retry_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              success_q, success_d;
    logic              txn_req_q, txn_req_d;
    logic              txn_in_q, txn_in_d;
    logic [6:0]        txn_addr_q, txn_addr_d;
    logic [3:0]        txn_endp_q, txn_endp_d;
    logic [DATA_W-1:0] txn_out_data_q, txn_out_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_ready_q, wr_ready_d;

    logic ack;
    assign ack = txn_req_q && bus.txn_ack;  // acks outside a request are ignored

    // Next-state and next-output logic for the burst FSM.
    always_comb begin
        state_d        = state_q;
        is_read_d      = is_read_q;
        page_d         = page_q;
        npages_d       = npages_q;
        pages_done_d   = pages_done_q;
        retry_d        = retry_q;
        abort_d        = abort_q;
        wbuf_d         = wbuf_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        success_d      = success_q;
        txn_req_d      = txn_req_q;
        txn_in_d       = txn_in_q;
        txn_addr_d     = txn_addr_q;
        txn_endp_d     = txn_endp_q;
        txn_out_data_d = txn_out_data_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = 1'b0;
        wr_ready_d     = wr_ready_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_read_d    = bus.is_read;
                    page_d       = bus.mem_page;
                    npages_d     = bus.num_pages;
                    pages_done_d = '0;
                    retry_d      = '0;
                    abort_d      = 1'b0;
                    success_d    = 1'b0;
                    busy_d       = 1'b1;
                    if (bus.num_pages == '0) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        success_d = 1'b1;
                    end else if (bus.num_pages > MAX_PG) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ADDR_REQ;
                    end
                end
            end

            S_ADDR_REQ: begin
                if (bus.abort) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    txn_req_d      = 1'b1;
                    txn_in_d       = 1'b0;
                    txn_addr_d     = 7'(DEV_ADDR);
                    txn_endp_d     = 4'(ADDR_ENDP);
                    txn_out_data_d = DATA_W'(page_q);
                    state_d        = S_ADDR_WAIT;
                end
            end

            S_ADDR_WAIT: begin
                if (bus.abort) abort_d = 1'b1;
                if (ack) begin
                    txn_req_d = 1'b0;
                    if (abort_q || bus.abort) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (bus.txn_ok) begin
                        retry_d    = '0;
                        state_d    = is_read_q ? S_DATA_REQ : S_WR_FETCH;
                        wr_ready_d = !is_read_q;
                    end else if (retry_q == RET_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_ADDR_REQ;
                    end
                end
            end

            S_WR_FETCH: begin
                if (bus.abort) begin
                    wr_ready_d = 1'b0;
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                end else if (bus.wr_valid && wr_ready_q) begin
                    wbuf_d     = bus.wr_data;
                    wr_ready_d = 1'b0;
                    state_d    = S_DATA_REQ;
                end
            end

            S_DATA_REQ: begin
                if (bus.abort) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    txn_req_d      = 1'b1;
                    txn_in_d       = is_read_q;
                    txn_addr_d     = 7'(DEV_ADDR);
                    txn_endp_d     = 4'(DATA_ENDP);
                    txn_out_data_d = is_read_q ? '0 : wbuf_q;
                    state_d        = S_DATA_WAIT;
                end
            end

            S_DATA_WAIT: begin
                if (bus.abort) abort_d = 1'b1;
                if (ack) begin
                    txn_req_d = 1'b0;
                    if (bus.txn_ok) begin
                        retry_d = '0;
                        // a completed read beat is delivered even when aborting
                        if (is_read_q) begin
                            rd_data_d  = bus.txn_in_data;
                            rd_valid_d = 1'b1;
                        end
                        if (abort_q || bus.abort) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end else if (abort_q || bus.abort || retry_q == RET_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_DATA_REQ;
                    end
                end
            end

            S_NEXT: begin
                pages_done_d = pages_done_q + 1'b1;
                page_d       = page_q + 1'b1;
                if (bus.abort) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (pages_done_q + 1'b1 == npages_q) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    success_d = 1'b1;
                end else begin
                    state_d = S_ADDR_REQ;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops everything to idle at once.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q        <= S_IDLE;
            is_read_q      <= 1'b0;
            page_q         <= '0;
            npages_q       <= '0;
            pages_done_q   <= '0;
            retry_q        <= '0;
            abort_q        <= 1'b0;
            wbuf_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            success_q      <= 1'b0;
            txn_req_q      <= 1'b0;
            txn_in_q       <= 1'b0;
            txn_addr_q     <= '0;
            txn_endp_q     <= '0;
            txn_out_data_q <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            wr_ready_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            is_read_q      <= is_read_d;
            page_q         <= page_d;
            npages_q       <= npages_d;
            pages_done_q   <= pages_done_d;
            retry_q        <= retry_d;
            abort_q        <= abort_d;
            wbuf_q         <= wbuf_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            success_q      <= success_d;
            txn_req_q      <= txn_req_d;
            txn_in_q       <= txn_in_d;
            txn_addr_q     <= txn_addr_d;
            txn_endp_q     <= txn_endp_d;
            txn_out_data_q <= txn_out_data_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            wr_ready_q     <= wr_ready_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.success      = success_q;
    assign bus.pages_done   = pages_done_q;
    assign bus.txn_req      = txn_req_q;
    assign bus.txn_in       = txn_in_q;
    assign bus.txn_addr     = txn_addr_q;
    assign bus.txn_endp     = txn_endp_q;
    assign bus.txn_out_data = txn_out_data_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.wr_ready     = wr_ready_q;
endmodule

// File: tb/tb_usb_burst_rw_seq.sv
// Directed bench for the burst sequencer: a vector table of whole bursts
// plus hand sequences for abort and mid-burst reset.
module tb_usb_burst_rw_seq;
    localparam int DATA_W = 64, ADDR_W = 16, MAX_PAGES = 4, MAX_RETRY = 8;
    localparam logic [6:0] DEV = 7'd5;
    localparam logic [3:0] AEP = 4'd4, DEP = 4'd8;

    logic clk = 1'b0;
    logic rst_L;
    always #5 clk = ~clk;

    usb_burst_rw_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PAGES(MAX_PAGES)) bus ();

    usb_burst_rw_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PAGES(MAX_PAGES), .MAX_RETRY(MAX_RETRY),
        .DEV_ADDR(5), .ADDR_ENDP(4), .DATA_ENDP(8)
    ) dut (.clk(clk), .rst_L(rst_L), .bus(bus));

    typedef struct {
        bit          is_in;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
        bit          ok;
    } txn_t;

    typedef struct {
        bit          rd;
        logic [15:0] page;
        logic [2:0]  n;
        int          data_fails;
        bit          all_fail;
        bit          exp_succ;
        logic [2:0]  exp_pd;
        int          exp_txn;
    } vec_t;

    txn_t        txn_log[$];
    logic [63:0] rd_log[$];
    logic [63:0] wr_q[$];
    int          ack_delay  = 1;
    int          data_fails = 0;
    bit          all_fail   = 1'b0;
    bit          req_seen   = 1'b0;
    bit          drop_chk   = 1'b0;
    logic [63:0] rd_base    = '0;
    int          rd_idx     = 0;
    int          n_chk      = 0;
    int          n_fail     = 0;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol handler model: acks after ack_delay cycles of txn_req, fails on demand.
    initial begin
        int hi_cnt;
        bit ok;
        hi_cnt = 0;
        bus.txn_ack = 1'b0; bus.txn_ok = 1'b0; bus.txn_in_data = '0;
        forever begin
            @(negedge clk);
            if (drop_chk) begin
                drop_chk = 1'b0;
                chk("req_drop_after_ack", 64'(bus.txn_req), 64'd0);
            end
            bus.txn_ack = 1'b0;
            if (rst_L && bus.txn_req) begin
                req_seen = 1'b1;
                hi_cnt++;
                if (hi_cnt >= ack_delay) begin
                    ok = !(all_fail || (bus.txn_endp == DEP && data_fails > 0));
                    if (!ok && !all_fail) data_fails--;
                    txn_log.push_back('{bus.txn_in, bus.txn_addr, bus.txn_endp, bus.txn_out_data, ok});
                    if (ok && bus.txn_in) begin
                        bus.txn_in_data = rd_base + 64'(rd_idx);
                        rd_idx++;
                    end
                    bus.txn_ok  = ok;
                    bus.txn_ack = 1'b1;
                    drop_chk    = 1'b1;
                    hi_cnt      = 0;
                end
            end else begin
                hi_cnt = 0;
            end
        end
    end

    // Write-beat source: presents the head of wr_q, pops after a transfer.
    initial begin
        bit xfer;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        forever begin
            @(posedge clk);
            xfer = bus.wr_valid && bus.wr_ready;
            @(negedge clk);
            if (xfer && wr_q.size() > 0) void'(wr_q.pop_front());
            bus.wr_valid = (wr_q.size() > 0);
            if (wr_q.size() > 0) bus.wr_data = wr_q[0];
        end
    end

    // Read-beat capture.
    initial forever begin
        @(negedge clk);
        if (bus.rd_valid) rd_log.push_back(bus.rd_data);
    end

    task automatic run_vec(input vec_t v, input int idx);
        txn_t exp_q[$];
        int   n_eff, e, cyc;
        n_eff = (v.n == 3'd0 || v.n > 3'(MAX_PAGES)) ? 0 : int'(v.n);
        txn_log.delete(); rd_log.delete(); wr_q.delete();
        req_seen = 1'b0; data_fails = v.data_fails; all_fail = v.all_fail;
        rd_idx = 0; rd_base = 64'hDEADBEEF_01234567 + 64'(idx) * 64'h100;
        for (int p = 0; p < n_eff; p++) begin
            logic [15:0] pg;
            logic [63:0] beat;
            pg   = v.page + 16'(p);
            beat = 64'hA5A5_0000_0000_0000 + 64'(idx * 16 + p);
            if (!v.rd) wr_q.push_back(beat);
            exp_q.push_back('{1'b0, DEV, AEP, 64'(pg), 1'b1});
            exp_q.push_back('{v.rd, DEV, DEP, v.rd ? 64'd0 : beat, 1'b1});
        end
        @(negedge clk);
        bus.start = 1'b1; bus.is_read = v.rd; bus.mem_page = v.page; bus.num_pages = v.n;
        @(negedge clk);
        bus.start = 1'b0;
        chk($sformatf("v%0d_busy", idx), 64'(bus.busy), 64'd1);
        cyc = 0;
        while (!bus.done && cyc < 3000) begin @(negedge clk); cyc++; end
        chk($sformatf("v%0d_done", idx), 64'(bus.done), 64'd1);
        chk($sformatf("v%0d_success", idx), 64'(bus.success), 64'(v.exp_succ));
        chk($sformatf("v%0d_pages_done", idx), 64'(bus.pages_done), 64'(v.exp_pd));
        @(negedge clk);
        chk($sformatf("v%0d_idle_hold", idx), 64'({bus.busy, bus.done, bus.success, bus.pages_done}),
            64'({1'b0, 1'b0, v.exp_succ, v.exp_pd}));
        chk($sformatf("v%0d_txn_count", idx), 64'(txn_log.size()), 64'(v.exp_txn));
        chk($sformatf("v%0d_req_seen", idx), 64'(req_seen), 64'(v.exp_txn > 0));
        e = 0;
        foreach (txn_log[i]) begin
            if (e < exp_q.size()) begin
                chk($sformatf("v%0d_txn%0d_fields", idx, i),
                    64'({txn_log[i].is_in, txn_log[i].addr, txn_log[i].endp}),
                    64'({exp_q[e].is_in, exp_q[e].addr, exp_q[e].endp}));
                if (!exp_q[e].is_in)
                    chk($sformatf("v%0d_txn%0d_data", idx, i), txn_log[i].data, exp_q[e].data);
                if (txn_log[i].ok) e++;
            end
        end
        chk($sformatf("v%0d_rd_count", idx), 64'(rd_log.size()), v.rd ? 64'(v.exp_pd) : 64'd0);
        foreach (rd_log[i])
            chk($sformatf("v%0d_rd%0d", idx, i), rd_log[i], rd_base + 64'(i));
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0; bus.is_read = 1'b0; bus.mem_page = '0; bus.num_pages = '0; bus.abort = 1'b0;
        rst_L = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({bus.busy, bus.done, bus.success, bus.pages_done, bus.txn_req, bus.txn_in,
                                bus.txn_addr, bus.txn_endp, bus.rd_valid, bus.wr_ready}), 64'd0);
        chk("reset_txn_data", bus.txn_out_data, 64'd0);
        chk("reset_rd_data", bus.rd_data, 64'd0);
        rst_L = 1'b1;

        //          rd    page       n     dfail all  succ  pd    txns
        vecs[0] = '{1'b1, 16'h3FFE, 3'd1, 0, 1'b0, 1'b1, 3'd1, 2};
        vecs[1] = '{1'b0, 16'h0010, 3'd2, 0, 1'b0, 1'b1, 3'd2, 4};
        vecs[2] = '{1'b1, 16'h0100, 3'd1, 2, 1'b0, 1'b1, 3'd1, 4};
        vecs[3] = '{1'b0, 16'h0200, 3'd1, 0, 1'b1, 1'b0, 3'd0, 8};
        vecs[4] = '{1'b1, 16'h0300, 3'd0, 0, 1'b0, 1'b1, 3'd0, 0};
        vecs[5] = '{1'b1, 16'h0300, 3'd5, 0, 1'b0, 1'b0, 3'd0, 0};
        vecs[6] = '{1'b1, 16'hFFFF, 3'd2, 0, 1'b0, 1'b1, 3'd2, 4};
        vecs[7] = '{1'b0, 16'h1234, 3'd4, 1, 1'b0, 1'b1, 3'd4, 9};
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Abort while waiting on the first data IN of a 3-page read; a stray
        // start in the same cycle must be ignored.
        txn_log.delete(); rd_log.delete(); wr_q.delete();
        data_fails = 0; all_fail = 1'b0; rd_idx = 0; rd_base = 64'h1111_2222_3333_4444; ack_delay = 4;
        @(negedge clk);
        bus.start = 1'b1; bus.is_read = 1'b1; bus.mem_page = 16'h0500; bus.num_pages = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.txn_req && bus.txn_endp == DEP) && cyc < 200) begin @(negedge clk); cyc++; end
        chk("abort_reach_data_wait", 64'(bus.txn_req && bus.txn_endp == DEP), 64'd1);
        bus.abort = 1'b1; bus.start = 1'b1; bus.num_pages = 3'd0;
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("abort_holds_req", 64'(bus.txn_req), 64'd1);
        cyc = 0;
        while (!bus.done && cyc < 200) begin @(negedge clk); cyc++; end
        chk("abort_done", 64'(bus.done), 64'd1);
        chk("abort_success", 64'(bus.success), 64'd0);
        chk("abort_pages_done", 64'(bus.pages_done), 64'd0);
        @(negedge clk);
        chk("abort_txn_count", 64'(txn_log.size()), 64'd2);
        chk("abort_rd_count", 64'(rd_log.size()), 64'd1);
        chk("abort_rd_data", rd_log.size() > 0 ? rd_log[0] : '1, 64'h1111_2222_3333_4444);
        ack_delay = 1;

        // Reset in the middle of a 4-page write, then a normal read.
        txn_log.delete(); wr_q.delete();
        for (int p = 0; p < 4; p++) wr_q.push_back(64'hBEEF_0000 + 64'(p));
        @(negedge clk);
        bus.start = 1'b1; bus.is_read = 1'b0; bus.mem_page = 16'h0700; bus.num_pages = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_burst_busy", 64'(bus.busy), 64'd1);
        rst_L = 1'b0;
        #1;
        chk("mid_reset_ctrl", 64'({bus.busy, bus.done, bus.success, bus.pages_done, bus.txn_req,
                                    bus.txn_endp, bus.rd_valid, bus.wr_ready}), 64'd0);
        chk("mid_reset_txn_data", bus.txn_out_data, 64'd0);
        wr_q.delete();
        repeat (2) @(negedge clk);
        rst_L = 1'b1;
        run_vec('{1'b1, 16'h0042, 3'd1, 0, 1'b0, 1'b1, 3'd1, 2}, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_burst_rw_seq.md
# usb_burst_rw_seq

Parametrised read/write transaction sequencer for the USB host. It sits between the host-side request interface (the `readData`/`writeData` task layer) and the USB protocol handler. It turns one request into a burst of up to `MAX_PAGES` consecutive memory-page transfers. Each page is an address OUT to `ADDR_ENDP` followed by a data OUT or IN on `DATA_ENDP`, with bounded per-transaction retry and abort support.

## Interface
- `DATA_W`, 64, data payload width per page
- `ADDR_W`, 16, memory page address width; sent zero-extended to `DATA_W`
- `MAX_PAGES`, 4, maximum pages per request
- `MAX_RETRY`, 8, total attempts per protocol transaction before failure
- `DEV_ADDR`, 5, USB device address driven on `txn_addr`
- `ADDR_ENDP`, 4, endpoint for page-address OUT
- `DATA_ENDP`, 8, endpoint for data OUT/IN
- `clk` in 1: single clock, all logic on posedge
- `rst_L` in 1: asynchronous, active-low reset
- `start` in 1: request strobe, sampled only in IDLE
- `is_read` in 1: 1 = read burst, 0 = write burst; captured with `start`
- `mem_page` in `ADDR_W`: first page address; captured with `start`
- `num_pages` in `$clog2(MAX_PAGES+1)`: page count; captured with `start`
- `abort` in 1: terminate burst
- `wr_data` in `DATA_W`, `wr_valid` in 1, `wr_ready` out 1: write-data handshake, one beat per page
- `rd_data` out `DATA_W`, `rd_valid` out 1: read-data beat, no backpressure
- `busy` out 1, `done` out 1, `success` out 1, `pages_done` out `$clog2(MAX_PAGES+1)`
- `txn_req` out 1, `txn_in` out 1 (1 = IN, 0 = OUT), `txn_addr` out 7, `txn_endp` out 4, `txn_out_data` out `DATA_W`: protocol request
- `txn_ack` in 1, `txn_ok` in 1, `txn_in_data` in `DATA_W`: protocol completion

## Operation
- **States:** IDLE, ADDR_REQ, ADDR_WAIT, WR_FETCH, DATA_REQ, DATA_WAIT, NEXT, DONE.
- **IDLE:**
  - `start=1` with `num_pages` in 1..`MAX_PAGES` captures the request and goes to ADDR_REQ.
  - `num_pages=0` goes to DONE with `success=1` and issues no transactions.
  - `num_pages>MAX_PAGES` goes to DONE with `success=0` and issues no transactions.
- **ADDR_REQ/ADDR_WAIT:**
  - Drive `txn_req=1`, `txn_in=0`, `txn_endp=ADDR_ENDP`, `txn_out_data` = zero-extended current page.
  - On `txn_ack&txn_ok`: go to WR_FETCH for a write, DATA_REQ for a read.
- **WR_FETCH:** `wr_ready=1` until `wr_valid`. The beat is latched and the state goes to DATA_REQ.
- **DATA_REQ/DATA_WAIT:**
  - Write: OUT to `DATA_ENDP` with the latched beat.
  - Read: IN from `DATA_ENDP`. On `txn_ack&txn_ok`, `rd_data<=txn_in_data` and `rd_valid` pulses 1 cycle.
- **NEXT:**
  - `pages_done++` and page++ (wraps modulo 2^`ADDR_W`).
  - If `pages_done==num_pages`, go to DONE with `success=1`; otherwise go to ADDR_REQ.
- **Retry:**
  - `txn_ack&!txn_ok` increments the per-transaction attempt counter.
  - While the count is below `MAX_RETRY`, the same request is re-issued with identical fields the next cycle.
  - At `MAX_RETRY` the state goes to DONE with `success=0`.
  - The counter clears when each new transaction starts.
- **Abort:**
  - In WR_FETCH, ADDR_REQ, DATA_REQ or NEXT: go to DONE with `success=0` next cycle.
  - In a *_WAIT state: hold until `txn_ack`, then go to DONE with `success=0`. A successful read beat still emits `rd_valid`.
- **DONE:** `done` pulses 1 cycle, then the state returns to IDLE. `success` and `pages_done` hold until the next accepted `start`.
- **`start` while busy:** ignored.

## Timing
- **Reset values:** all outputs 0 (`busy`, `done`, `success`, `pages_done`, `txn_*`, `rd_*`, `wr_ready`); state IDLE; counters 0. Reset mid-burst returns to IDLE immediately, with no `done` pulse.
- **Outputs:** all registered.
- **`busy`:** 1 from the cycle after `start` is accepted through the `done` cycle inclusive.
- **`txn_req`:**
  - Rises the cycle after entering ADDR_REQ/DATA_REQ (start accept +1).
  - Stays high with stable fields until the cycle `txn_ack` is sampled high, and drops the following cycle.
  - Re-issue after a failure or a new request rises no earlier than 1 cycle after the drop (minimum 1 low cycle between requests).
- **`txn_ack`:** earliest one cycle after `txn_req` rises. An ack while `txn_req=0` is ignored.
- **Read beat:** `rd_valid` asserts the cycle after the IN ack.
- **Write beat:** the `wr_valid`/`wr_ready` transfer occurs on the cycle both are high.
- **Zero-wait protocol throughput:** 2 transactions per page.

## Test plan
- **Single read:** read, `mem_page=16'h3FFE`, `num_pages=1`, protocol acks ok with `txn_in_data=64'hDEADBEEF_01234567` -> OUT `ADDR_ENDP` data `64'h3FFE`, IN `DATA_ENDP`, `rd_data` matches, `done` with `success=1`, `pages_done=1`.
- **Two-page write:** write, `mem_page=16'h0010`, `num_pages=2`, beats A and B -> address OUTs `0x10` and `0x11` each followed by the corresponding data OUT, `success=1`.
- **Retry recovers:** first two data acks have `txn_ok=0`, third ok -> exactly 3 identical requests, `success=1`.
- **Retry exhausted:** all acks fail -> exactly `MAX_RETRY=8` attempts, `success=0`, `pages_done=0`.
- **Count boundaries:** `num_pages=0` -> `done` with `success=1` and no `txn_req`. `num_pages=5` -> `success=0` and no `txn_req`. Read at `mem_page=16'hFFFF`, 2 pages -> second address is `0x0000`.
- **Abort and reset:** abort asserted during DATA_WAIT of page 1 of 3 -> waits for ack, then `success=0`, `pages_done=0`. `rst_L` low mid-burst -> all outputs 0 the same cycle, and a following `start` works normally.
